// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an NxN output-stationary systolic array: loads K skewed
// operand beats, flushes the pipeline, captures the result and emits it once.
module systolic_array_ctrl #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int K  = 3
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              s_axis_valid,
    input  logic [2*N*DW-1:0] s_axis_data,
    output logic              s_axis_ready,
    output logic              m_axis_valid,
    output logic [N*N*AW-1:0] m_axis_data,
    input  logic              m_axis_ready,
    output logic              arr_en,
    output logic              arr_clear,
    output logic [N*DW-1:0]   arr_a_in,
    output logic [N*DW-1:0]   arr_b_in,
    input  logic [N*N*AW-1:0] arr_result,
    output logic              busy
);

    localparam int BCW = (K > 1) ? $clog2(K) : 1;
    localparam int FCW = $clog2(2 * N);
    localparam logic [BCW-1:0] LAST_BEAT  = BCW'(K - 1);
    localparam logic [FCW-1:0] LAST_FLUSH = FCW'(2 * N - 2);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_FLUSH,
        S_OUT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BCW-1:0]      r_beat_cnt;
    logic [FCW-1:0]      r_flush_cnt;
    logic [N*N*AW-1:0]   r_m_data;
    logic                w_s_hs;
    logic [N*DW-1:0]     w_a_src;
    logic [N*DW-1:0]     w_b_src;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values of its peers, exactly like the hardware.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state     <= S_CLEAR;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_m_data    <= '0;
        end else begin
            r_state <= w_next;
            if (w_s_hs) begin
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BCW'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= (r_flush_cnt == LAST_FLUSH) ? '0 : r_flush_cnt + FCW'(1);
                if (r_flush_cnt == LAST_FLUSH) begin
                    r_m_data <= arr_result;
                end
            end
        end
    end

    // NOTE: every output and w_next gets a default before the case so no path
    // through this block leaves a value unassigned (which would infer a latch).
    always_comb begin
        w_next       = r_state;
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        arr_en       = 1'b0;
        arr_clear    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_CLEAR: begin
                arr_clear = 1'b1;
                w_next    = S_LOAD;
            end
            S_LOAD: begin
                s_axis_ready = 1'b1;
                arr_en       = s_axis_valid;
                busy         = (r_beat_cnt != '0);
                if (s_axis_valid && (r_beat_cnt == LAST_BEAT)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                arr_en = 1'b1;
                if (r_flush_cnt == LAST_FLUSH) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                m_axis_valid = 1'b1;
                if (m_axis_ready) begin
                    w_next = S_CLEAR;
                end
            end
            default: w_next = S_CLEAR;
        endcase
        // Reset forces a quiet interface with the array held in clear.
        if (axi_rst) begin
            s_axis_ready = 1'b0;
            m_axis_valid = 1'b0;
            arr_en       = 1'b0;
            arr_clear    = 1'b1;
            busy         = 1'b0;
        end
    end

    assign w_s_hs      = s_axis_ready & s_axis_valid;
    assign m_axis_data = axi_rst ? '0 : r_m_data;

    // Outside LOAD zeros are injected, which drains the skew chains during FLUSH.
    assign w_a_src = s_axis_ready ? s_axis_data[N*DW-1:0] : '0;
    assign w_b_src = s_axis_ready ? s_axis_data[2*N*DW-1:N*DW] : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign arr_a_in[DW-1:0] = w_a_src[DW-1:0];
            assign arr_b_in[DW-1:0] = w_b_src[DW-1:0];
        end else begin : g_delay
            logic [DW-1:0] r_a_skew [gi];
            logic [DW-1:0] r_b_skew [gi];

            // NOTE: these small delay lines are reset explicitly; stale operands
            // left over from an aborted job would otherwise leak into the next one.
            always_ff @(posedge axi_clk) begin
                if (axi_rst) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_skew[s] <= '0;
                        r_b_skew[s] <= '0;
                    end
                end else if (arr_en) begin
                    r_a_skew[0] <= w_a_src[DW*gi+:DW];
                    r_b_skew[0] <= w_b_src[DW*gi+:DW];
                    for (int s = 1; s < gi; s++) begin
                        r_a_skew[s] <= r_a_skew[s-1];
                        r_b_skew[s] <= r_b_skew[s-1];
                    end
                end
            end

            assign arr_a_in[DW*gi+:DW] = axi_rst ? '0 : r_a_skew[gi-1];
            assign arr_b_in[DW*gi+:DW] = axi_rst ? '0 : r_b_skew[gi-1];
        end
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: behavioural MAC array on the arr_* ports and
// a scoreboard of reference matrix products checked on every result handshake.
module tb_systolic_array_ctrl;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int K  = 3;
    localparam int BW = 2 * N * DW;
    localparam int RW = N * N * AW;

    typedef logic [BW-1:0] job_t [K];

    logic          clk;
    logic          axi_rst;
    logic          s_axis_valid;
    logic [BW-1:0] s_axis_data;
    logic          s_axis_ready;
    logic          m_axis_valid;
    logic [RW-1:0] m_axis_data;
    logic          m_axis_ready;
    logic          arr_en;
    logic          arr_clear;
    logic [N*DW-1:0] arr_a_in;
    logic [N*DW-1:0] arr_b_in;
    logic [RW-1:0] arr_result;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [RW-1:0] sb [$];

    systolic_array_ctrl #(.N(N), .DW(DW), .AW(AW), .K(K)) dut (
        .axi_clk      (clk),
        .axi_rst      (axi_rst),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_ready (m_axis_ready),
        .arr_en       (arr_en),
        .arr_clear    (arr_clear),
        .arr_a_in     (arr_a_in),
        .arr_b_in     (arr_b_in),
        .arr_result   (arr_result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array: A moves right, B moves down.
    logic [AW-1:0] m_acc [N][N];
    logic [DW-1:0] m_pa  [N][N];
    logic [DW-1:0] m_pb  [N][N];

    function automatic logic [DW-1:0] a_at(input int i, input int j);
        return (j == 0) ? arr_a_in[DW*i+:DW] : m_pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_at(input int i, input int j);
        return (i == 0) ? arr_b_in[DW*j+:DW] : m_pb[i-1][j];
    endfunction

    function automatic logic [AW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[AW-1:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clear) begin
                    m_acc[i][j] <= '0;
                    m_pa[i][j]  <= '0;
                    m_pb[i][j]  <= '0;
                end else if (arr_en) begin
                    m_acc[i][j] <= m_acc[i][j] + mac_term(a_at(i, j), b_at(i, j));
                    m_pa[i][j]  <= a_at(i, j);
                    m_pb[i][j]  <= b_at(i, j);
                end
            end
        end
    end

    always_comb begin
        arr_result = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                arr_result[AW*(i*N+j)+:AW] = m_acc[i][j];
            end
        end
    end

    // Reference C = A x B straight from the job beats.
    function automatic logic [RW-1:0] matmul(input job_t job);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < K; k++) begin
                    s += int'($signed(job[k][DW*i+:DW])) * int'($signed(job[k][N*DW+DW*j+:DW]));
                end
                r[AW*(i*N+j)+:AW] = s[AW-1:0];
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Result monitor: every handshake pops one reference product.
    always @(negedge clk) begin
        if (m_axis_valid && m_axis_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", m_axis_valid, 1'b0);
            end else begin
                check("result", m_axis_data, sb.pop_front());
            end
        end
    end

    task automatic random_job(output job_t j);
        logic [63:0] r;
        for (int k = 0; k < K; k++) begin
            r = {$urandom(), $urandom()};
            j[k] = r[BW-1:0];
        end
    endtask

    task automatic send_job(input job_t job, input bit bubbles, input int nbeats,
                            input bit push, output int t0);
        int  k = 0;
        int  g = 0;
        bit  skip = 1'b0;
        t0 = -1;
        if (push) sb.push_back(matmul(job));
        while (k < nbeats && g < 100) begin
            s_axis_valid = !skip;
            s_axis_data  = s_axis_valid ? job[k] : '1;
            #1;
            if (s_axis_ready) begin
                check(bubbles ? "bubble_en" : "load_en", arr_en, s_axis_valid);
                if (s_axis_valid) begin
                    if (k == 0) t0 = cyc;
                    k++;
                end
            end else begin
                check("ignored_en", arr_en, 1'b0);
            end
            if (bubbles) skip = !skip;
            g++;
            tick();
        end
        s_axis_valid = 1'b0;
        if (k < nbeats) check("send_timeout", k, nbeats);
    endtask

    task automatic wait_valid(input bit junk, output int tv);
        int g = 0;
        s_axis_valid = junk;
        #1;
        while (!m_axis_valid && g < 100) begin
            check("flush_en", arr_en, 1'b1);
            check("flush_rdy", s_axis_ready, 1'b0);
            tick();
            if (junk) s_axis_data = {$urandom(), $urandom()};
            #1;
            g++;
        end
        s_axis_valid = 1'b0;
        tv = cyc;
        if (!m_axis_valid) check("valid_timeout", m_axis_valid, 1'b1);
    endtask

    // Called in the handshake cycle with m_axis_ready high.
    task automatic finish_out();
        tick();
        #1;
        check("clr_pulse", arr_clear, 1'b1);
        check("clr_rdy", s_axis_ready, 1'b0);
        tick();
        #1;
        check("rdy_back", s_axis_ready, 1'b1);
        check("clr_done", arr_clear, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        job_t          id_job;
        job_t          sg_job;
        job_t          rj;
        job_t          zj;
        int            t0;
        int            tv;
        logic [RW-1:0] held;

        axi_rst      = 1'b1;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        m_axis_ready = 1'b1;
        tick();
        tick();
        #1;
        check("rst_clear", arr_clear, 1'b1);
        check("rst_srdy", s_axis_ready, 1'b0);
        check("rst_mval", m_axis_valid, 1'b0);
        check("rst_en", arr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mdata", m_axis_data, '0);
        axi_rst = 1'b0;
        #1;
        check("post_rst_clear", arr_clear, 1'b1);
        check("post_rst_busy", busy, 1'b1);
        tick();
        #1;
        check("load_rdy", s_axis_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Identity x B with latency check.
        id_job = '{48'h030201_000001, 48'h060504_000100, 48'h090807_010000};
        send_job(id_job, 1'b0, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        check("latency", tv - t0, K + 2 * N - 1);
        finish_out();

        // Same job with input bubbles every other cycle.
        send_job(id_job, 1'b1, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        finish_out();

        // Signed operands; junk valid beats during FLUSH must be ignored.
        sg_job = '{48'h020202_FFFFFF, 48'h020202_FFFFFF, 48'h020202_FFFFFF};
        send_job(sg_job, 1'b0, K, 1'b1, t0);
        wait_valid(1'b1, tv);
        finish_out();

        // Back-pressure on the result for 10 cycles.
        random_job(rj);
        m_axis_ready = 1'b0;
        send_job(rj, 1'b0, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        held = m_axis_data;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            check("hold_valid", m_axis_valid, 1'b1);
            check("hold_data", m_axis_data, held);
            check("hold_srdy", s_axis_ready, 1'b0);
            check("hold_clear", arr_clear, 1'b0);
        end
        m_axis_ready = 1'b1;
        finish_out();

        // Reset after two beats: the partial job must vanish.
        random_job(rj);
        send_job(rj, 1'b0, 2, 1'b0, t0);
        s_axis_valid = 1'b1;
        s_axis_data  = rj[2];
        axi_rst      = 1'b1;
        #1;
        check("mid_rst_srdy", s_axis_ready, 1'b0);
        check("mid_rst_en", arr_en, 1'b0);
        check("mid_rst_clear", arr_clear, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_a", arr_a_in, '0);
        check("mid_rst_b", arr_b_in, '0);
        check("mid_rst_mdata", m_axis_data, '0);
        tick();
        axi_rst      = 1'b0;
        s_axis_valid = 1'b0;
        #1;
        check("after_rst_clear", arr_clear, 1'b1);
        check("after_rst_en", arr_en, 1'b0);
        check("after_rst_mval", m_axis_valid, 1'b0);
        check("after_rst_a", arr_a_in, '0);
        check("after_rst_b", arr_b_in, '0);
        check("after_rst_mdata", m_axis_data, '0);
        tick();
        #1;
        check("after_rst_rdy", s_axis_ready, 1'b1);
        send_job(id_job, 1'b0, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        finish_out();

        // Back-to-back jobs; the second is all zeros.
        random_job(rj);
        zj = '{default: '0};
        send_job(rj, 1'b0, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        finish_out();
        send_job(zj, 1'b0, K, 1'b1, t0);
        wait_valid(1'b0, tv);
        finish_out();

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
